// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage running the data-SRAM req/addr_ok/data_ok handshake for loads/stores.
// Optional misaligned-access trap is enabled by defining MEM_ALIGN_CHECK_EN.
//  state | meaning
//  IDLE  | no payload held
//  REQ   | data_req asserted, waiting for addr_ok
//  WAIT  | request accepted, waiting for data_ok
//  DONE  | result ready, waiting for write-back to accept
module mem_stage #(
  parameter int EXE_TO_MEM_BUS_WD = 116,
  parameter int MEM_TO_WB_BUS_WD  = 112,
  parameter int MEM_TO_BY_BUS_WD  = 39
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  input  logic                         EXE_to_MEM_valid,
  output logic                         MEM_allow_in,
  output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
  output logic                         MEM_to_WB_valid,
  input  logic                         WB_allow_in,
  output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus,
  output logic                         data_req,
  output logic                         data_wr,
  output logic [1:0]                   data_size,
  output logic [31:0]                  data_addr,
  output logic [3:0]                   data_wstrb,
  output logic [31:0]                  data_wdata,
  input  logic                         data_addr_ok,
  input  logic                         data_data_ok,
  input  logic [31:0]                  data_rdata,
  output logic                         mem_align_err
);
  localparam int PL_WD = 112;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;

  logic [1:0]       state_q, state_d, start_state;
  logic             mem_valid_q, mem_valid_d;
  logic [PL_WD-1:0] payload_q, payload_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        is_load, is_store, is_mem, rf_w_en, rf_w_sel, rf_w_en_eff;
  logic [1:0]  mem_size, ram_wd;
  logic [31:0] store_data, alu_result, inst_pc, r_data, fwd_data;
  logic [2:0]  vstage;
  logic [4:0]  rf_w_addr;
  logic [3:0]  b_en;
  logic        in_is_mem, in_misalign, align_err, data_hit, ready_go, data_valid;
  logic        unused_pad;

  // The top bits of the EXE bus above the 112 payload bits carry nothing.
  assign unused_pad = ^EXE_to_MEM_bus[EXE_TO_MEM_BUS_WD-1:PL_WD];

  assign {is_load, is_store, mem_size, store_data, vstage, rf_w_en, rf_w_sel,
          ram_wd, rf_w_addr, alu_result, inst_pc} = payload_q;
  assign is_mem    = is_load | is_store;
  assign in_is_mem = EXE_to_MEM_bus[111] | EXE_to_MEM_bus[110];

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr[0];
      default: return |addr;
    endcase
  endfunction
  assign in_misalign = is_misaligned(EXE_to_MEM_bus[109:108], EXE_to_MEM_bus[33:32]);
  assign align_err   = mem_valid_q & is_mem & is_misaligned(mem_size, alu_result[1:0]);
`else
  assign in_misalign = 1'b0;
  assign align_err   = 1'b0;
`endif

  assign start_state = (in_is_mem & ~in_misalign) ? REQ : DONE;
  assign data_hit    = mem_valid_q & data_data_ok &
                       (((state_q == REQ) & data_addr_ok) | (state_q == WAIT));
  assign ready_go    = mem_valid_q & ((state_q == DONE) | data_hit);

  assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q & ready_go;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    payload_d   = payload_q;
    rdata_d     = rdata_q;
    if (data_hit) rdata_d = data_rdata;
    if (MEM_allow_in) begin
      mem_valid_d = EXE_to_MEM_valid;
      if (EXE_to_MEM_valid) begin
        payload_d = EXE_to_MEM_bus[PL_WD-1:0];
        state_d   = start_state;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        REQ:     if (data_addr_ok) state_d = data_data_ok ? DONE : WAIT;
        WAIT:    if (data_data_ok) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      payload_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      payload_q   <= payload_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    b_en = 4'b1111;
    case (mem_size)
      2'd0:    b_en = 4'b0001 << alu_result[1:0];
      2'd1:    b_en = alu_result[1] ? 4'b1100 : 4'b0011;
      default: b_en = 4'b1111;
    endcase
  end

  always_comb begin
    data_wdata = store_data;
    case (mem_size)
      2'd0:    data_wdata = {4{store_data[7:0]}};
      2'd1:    data_wdata = {2{store_data[15:0]}};
      default: data_wdata = store_data;
    endcase
  end

  assign data_req      = mem_valid_q & (state_q == REQ);
  assign data_wr       = is_store;
  assign data_size     = mem_size;
  assign data_addr     = alu_result;
  assign data_wstrb    = is_store ? b_en : 4'b0000;
  assign mem_align_err = align_err;

  // Response data is visible on its data_ok cycle; the register covers write-back stalls.
  assign r_data      = data_hit ? data_rdata : rdata_q;
  assign rf_w_en_eff = rf_w_en & ~align_err;
  assign fwd_data    = (rf_w_addr == 5'd0) ? 32'd0 : (is_load ? r_data : alu_result);
  assign data_valid  = mem_valid_q & (vstage[1] | vstage[0]) & (~is_load | ready_go);

  assign MEM_to_WB_bus = {vstage, rf_w_en_eff, rf_w_sel, ram_wd, b_en, r_data,
                          rf_w_addr, alu_result, inst_pc};
  // 39 bits leave room for one write flag: MEM_valid and rf_w_en share the lsb.
  assign MEM_to_BY_bus = {rf_w_addr, fwd_data, data_valid, mem_valid_q & rf_w_en_eff};
endmodule
